// File: rtl/psum_collector_if.sv
// Handshake bundle between the PE psum stream, the collector and the output writer.
// The producer/consumer side uses modport master; the collector uses modport slave.
interface psum_collector_if #(
    parameter int ACC_W = 16
);
    logic                    in_valid;
    logic signed [7:0]       in_psum;
    logic                    in_ready;
    logic                    out_valid;
    logic signed [ACC_W-1:0] out_data;
    logic                    out_ready;

    modport master (
        output in_valid,
        output in_psum,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output out_ready
    );

    modport slave (
        input  in_valid,
        input  in_psum,
        output in_ready,
        output out_valid,
        output out_data,
        input  out_ready
    );
endinterface

// File: rtl/psum_collector.sv
// Sums N_CH consecutive signed psums into an ACC_W total and queues totals in a FWFT FIFO.
// Optional macro PSUM_RELU_EN clamps negative totals to zero on their way into the FIFO.
module psum_collector #(
    parameter int N_CH  = 3,
    parameter int ACC_W = 16,
    parameter int DEPTH = 4,
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             sys_clk,
    input  logic             CLR,
    psum_collector_if.slave  bus,
    output logic [CH_W-1:0]  ch_idx,
    output logic [CNT_W-1:0] fifo_cnt,
    output logic             drop_err
);
    localparam int PTR_W = $clog2(DEPTH);

    logic signed [ACC_W-1:0] acc_reg;
    logic [CH_W-1:0]         ch_idx_reg;
    logic [PTR_W-1:0]        wr_ptr_reg;
    logic [PTR_W-1:0]        rd_ptr_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic signed [ACC_W-1:0] out_data_reg;
    logic                    drop_err_reg;
    logic signed [ACC_W-1:0] mem [DEPTH];

    logic                    accept;
    logic                    last_ch;
    logic                    push;
    logic                    pop;
    logic signed [ACC_W-1:0] psum_ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] push_val;
    logic [CH_W-1:0]         ch_idx_next;
    logic [CNT_W-1:0]        cnt_after_pop;
    logic [CNT_W-1:0]        cnt_next;
    logic [PTR_W-1:0]        rd_ptr_next;
    logic signed [ACC_W-1:0] head_next;

    // Flow control depends on registered occupancy only, never on same-cycle inputs.
    assign bus.in_ready  = (cnt_reg != CNT_W'(DEPTH));
    assign bus.out_valid = (cnt_reg != '0);
    assign bus.out_data  = out_data_reg;
    assign ch_idx        = ch_idx_reg;
    assign fifo_cnt      = cnt_reg;
    assign drop_err      = drop_err_reg;

    assign accept   = bus.in_valid & bus.in_ready;
    assign last_ch  = (ch_idx_reg == CH_W'(N_CH - 1));
    assign push     = accept & last_ch;
    assign pop      = bus.out_valid & bus.out_ready;
    assign psum_ext = ACC_W'(bus.in_psum);
    assign sum      = acc_reg + psum_ext;

`ifdef PSUM_RELU_EN
    assign push_val = sum[ACC_W-1] ? '0 : sum;
`else
    assign push_val = sum;
`endif

    assign ch_idx_next = last_ch ? '0 : ch_idx_reg + CH_W'(1);

    // The output register is loaded with next cycle's head so out_data is FWFT yet holds
    // its last value while the FIFO is empty.
    always_comb begin
        cnt_after_pop = cnt_reg - CNT_W'(pop);
        cnt_next      = cnt_after_pop + CNT_W'(push);
        rd_ptr_next   = rd_ptr_reg + PTR_W'(pop);
        head_next     = out_data_reg;
        if (cnt_next != '0) begin
            if (cnt_after_pop == '0) begin
                head_next = push_val;
            end else begin
                head_next = mem[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (CLR) begin
            acc_reg      <= '0;
            ch_idx_reg   <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            cnt_reg      <= '0;
            out_data_reg <= '0;
            drop_err_reg <= 1'b0;
        end else begin
            if (accept) begin
                acc_reg    <= last_ch ? '0 : sum;
                ch_idx_reg <= ch_idx_next;
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (bus.in_valid && !bus.in_ready) begin
                drop_err_reg <= 1'b1;
            end
            rd_ptr_reg   <= rd_ptr_next;
            cnt_reg      <= cnt_next;
            out_data_reg <= head_next;
        end
    end

    // Storage carries no reset; entries are only read once the pointers say they are valid.
    always_ff @(posedge sys_clk) begin
        if (push && !CLR) begin
            mem[wr_ptr_reg] <= push_val;
        end
    end
endmodule
